// File: rtl/booth_product_bcd_if.sv
// Start/done bundle between a product producer and the BCD converter.
//
// Handshake: the producer holds `product` and raises `start`; the request is
// taken on a rising clk edge only while `ready` is 1, and `product` is sampled
// on that edge alone. `start` seen while `ready` is 0 is dropped, not queued.
// `done` pulses for exactly one cycle when `sign`/`bcd` have just been
// refreshed. `sign`/`bcd` hold their value until the next `done`.
interface booth_product_bcd_if #(
  parameter int N      = 4,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [2*N-1:0]        product;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;
  logic [1:0]            state_dbg;

  modport master (
    output start, product,
    input  ready, busy, done, sign, bcd, state_dbg
  );

  modport slave (
    input  start, product,
    output ready, busy, done, sign, bcd, state_dbg
  );
endinterface

// File: rtl/booth_product_bcd.sv
// Signed 2N-bit product to sign + magnitude BCD, one double-dabble bit per clock.
// IDLE captures sign/magnitude, CONVERT performs 2N add-3/shift steps, DONE
// publishes the result for one cycle and returns to IDLE.
module booth_product_bcd #(
  parameter int N      = 4,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  booth_product_bcd_if.slave   bus
);
  localparam int PW = 2 * N;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(2 * N + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   mag_q, mag_d;
  logic [BW-1:0]   work_q, work_d;
  logic            sign_r_q, sign_r_d;
  logic            sign_q, sign_d;
  logic [BW-1:0]   bcd_q, bcd_d;

  logic [BW-1:0]   adj;
  logic            last_iter;

  assign last_iter = (count_q == CW'(PW - 1));

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      mag_q    <= '0;
      work_q   <= '0;
      sign_r_q <= 1'b0;
      sign_q   <= 1'b0;
      bcd_q    <= '0;
    end else begin
      count_q  <= count_d;
      mag_q    <= mag_d;
      work_q   <= work_d;
      sign_r_q <= sign_r_d;
      sign_q   <= sign_d;
      bcd_q    <= bcd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_CONVERT;
      S_CONVERT: if (last_iter) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Add-3 correction of each BCD digit before the shift; digits never carry
  // into each other because a corrected digit is at most 12 (4 + 3 + 5 max).
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  // Datapath next values: capture on accept, shift while converting,
  // publish result on the edge that enters DONE.
  always_comb begin
    count_d  = count_q;
    mag_d    = mag_q;
    work_d   = work_q;
    sign_r_d = sign_r_q;
    sign_d   = sign_q;
    bcd_d    = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sign_r_d = bus.product[PW-1];
          // The most negative product negates to itself, which is the right
          // magnitude when read as unsigned.
          mag_d    = bus.product[PW-1] ? (~bus.product + PW'(1)) : bus.product;
          work_d   = '0;
          count_d  = '0;
        end
      end
      S_CONVERT: begin
        {work_d, mag_d} = {adj, mag_q} << 1;
        count_d         = count_q + CW'(1);
        if (last_iter) begin
          bcd_d  = work_d;
          sign_d = sign_r_q;
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    bus.ready     = (state_q == S_IDLE);
    bus.busy      = (state_q == S_CONVERT);
    bus.done      = (state_q == S_DONE);
    bus.state_dbg = state_q;
    bus.sign      = sign_q;
    bus.bcd       = bcd_q;
  end
endmodule

// File: tb/tb_booth_product_bcd.sv
// Bench for booth_product_bcd: one N=4 and one N=8 instance, directed corner
// cases plus random products against a decimal reference model.
module tb_booth_product_bcd;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  booth_product_bcd_if #(.N(4), .DIGITS(3)) i4 ();
  booth_product_bcd_if #(.N(8), .DIGITS(5)) i8 ();

  booth_product_bcd #(.N(4), .DIGITS(3)) dut4 (.clk(clk), .reset(reset), .bus(i4.slave));
  booth_product_bcd #(.N(8), .DIGITS(5)) dut8 (.clk(clk), .reset(reset), .bus(i8.slave));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: magnitude of a signed value as packed decimal digits.
  function automatic logic [31:0] ref_bcd(input longint v);
    logic [31:0] r;
    longint m;
    r = '0;
    m = (v < 0) ? -v : v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic wait_ready4();
    int k;
    k = 0;
    @(negedge clk);
    while (!i4.ready && k < 40) begin @(negedge clk); k++; end
    chk("ready4_wait", 32'(i4.ready), 32'd1);
  endtask

  task automatic wait_ready8();
    int k;
    k = 0;
    @(negedge clk);
    while (!i8.ready && k < 60) begin @(negedge clk); k++; end
    chk("ready8_wait", 32'(i8.ready), 32'd1);
  endtask

  // Full N=4 conversion: latency, hold of old result, busy, done width.
  task automatic conv4(input logic [7:0] p);
    int k;
    logic [11:0] old_bcd;
    logic old_sign;
    wait_ready4();
    old_bcd = i4.bcd;
    old_sign = i4.sign;
    i4.start = 1'b1;
    i4.product = p;
    @(posedge clk);
    @(negedge clk);
    i4.start = 1'b0;
    i4.product = 8'($urandom);
    chk("busy4", 32'({i4.busy, i4.ready}), 32'b10);
    k = 0;
    while (!i4.done && k < 40) begin
      chk("hold4", 32'({old_sign, old_bcd}), 32'({i4.sign, i4.bcd}));
      @(negedge clk);
      k++;
    end
    chk("latency4", 32'(k), 32'd8);
    chk("sign4", 32'(i4.sign), 32'(p[7]));
    chk("bcd4", 32'(i4.bcd), ref_bcd(longint'($signed(p))) & 32'hFFF);
    @(negedge clk);
    chk("done4_width", 32'({i4.done, i4.ready}), 32'b01);
  endtask

  task automatic conv8(input logic [15:0] p);
    int k;
    logic [19:0] old_bcd;
    logic old_sign;
    wait_ready8();
    old_bcd = i8.bcd;
    old_sign = i8.sign;
    i8.start = 1'b1;
    i8.product = p;
    @(posedge clk);
    @(negedge clk);
    i8.start = 1'b0;
    i8.product = 16'($urandom);
    chk("busy8", 32'({i8.busy, i8.ready}), 32'b10);
    k = 0;
    while (!i8.done && k < 60) begin
      chk("hold8", 32'({old_sign, old_bcd}), 32'({i8.sign, i8.bcd}));
      @(negedge clk);
      k++;
    end
    chk("latency8", 32'(k), 32'd16);
    chk("sign8", 32'(i8.sign), 32'(p[15]));
    chk("bcd8", 32'(i8.bcd), ref_bcd(longint'($signed(p))) & 32'hFFFFF);
    @(negedge clk);
    chk("done8_width", 32'({i8.done, i8.ready}), 32'b01);
  endtask

  initial begin
    int k;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    i4.start = 1'b0;
    i4.product = '0;
    i8.start = 1'b0;
    i8.product = '0;
    #3;
    chk("rst4_status", 32'({i4.ready, i4.busy, i4.done}), 32'b100);
    chk("rst4_out", 32'({i4.sign, i4.bcd}), 32'd0);
    chk("rst8_status", 32'({i8.ready, i8.busy, i8.done}), 32'b100);
    chk("rst8_out", 32'({i8.sign, i8.bcd}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed N=4 corners
    conv4(8'h00);
    conv4(8'h7F);
    conv4(8'h80);

    // Start held through a conversion: second request is taken only once
    // ready returns, with whatever product is present then.
    wait_ready4();
    i4.start = 1'b1;
    i4.product = 8'hF9;
    @(posedge clk);
    @(negedge clk);
    i4.product = 8'h2A;
    k = 0;
    while (!i4.done && k < 40) begin @(negedge clk); k++; end
    chk("held_lat", 32'(k), 32'd8);
    chk("held_first", 32'({i4.sign, i4.bcd}), 32'h1007);
    k = 0;
    @(negedge clk);
    k++;
    while (!i4.done && k < 40) begin
      chk("held_hold", 32'({i4.sign, i4.bcd}), 32'h1007);
      @(negedge clk);
      k++;
    end
    chk("held_period", 32'(k), 32'd10);
    chk("held_second", 32'({i4.sign, i4.bcd}), 32'h0042);
    i4.start = 1'b0;
    @(negedge clk);
    chk("held_done_low", 32'(i4.done), 32'd0);

    // Reset during the fourth CONVERT cycle aborts the conversion.
    wait_ready4();
    i4.start = 1'b1;
    i4.product = 8'h64;
    @(posedge clk);
    @(negedge clk);
    i4.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_status", 32'({i4.ready, i4.busy, i4.done}), 32'b100);
    chk("abort_out", 32'({i4.sign, i4.bcd}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i4.done) k++;
    end
    chk("abort_no_done", 32'(k), 32'd0);
    conv4(8'hC4);

    // Random N=4
    for (int i = 0; i < 12; i++) conv4(8'($urandom_range(0, 255)));

    // N=8 corners and random
    conv8(16'h8000);
    conv8(16'h7FFF);
    conv8(16'hFFFF);
    for (int i = 0; i < 6; i++) conv8(16'($urandom_range(0, 65535)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
